// File: rtl/cache_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_arbiter_if
// Brief    : Bundles the icache, dcache and memory-bus signals of the refill
//            arbiter. The master modport is the arbiter's view. The slave
//            modport is the view of the surrounding caches and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  // icache side
  logic              ic_req_i;
  logic              ic_kill_i;
  logic [ADDR_W-1:0] ic_addr_i;
  logic              ic_ack_o;
  logic [LINE_W-1:0] ic_rdata_o;
  // dcache side
  logic              dc_req_i;
  logic              dc_we_i;
  logic [ADDR_W-1:0] dc_addr_i;
  logic [LINE_W-1:0] dc_wdata_i;
  logic              dc_ack_o;
  logic [LINE_W-1:0] dc_rdata_o;
  // memory side
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [LINE_W-1:0] mem_rdata_i;

  // Arbiter view
  modport master (
    input  ic_req_i, ic_kill_i, ic_addr_i,
    output ic_ack_o, ic_rdata_o,
    input  dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
    output dc_ack_o, dc_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  // Cache controllers / memory view
  modport slave (
    output ic_req_i, ic_kill_i, ic_addr_i,
    input  ic_ack_o, ic_rdata_o,
    output dc_req_i, dc_we_i, dc_addr_i, dc_wdata_i,
    input  dc_ack_o, dc_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_arbiter
// Brief    : Round-robin arbiter that shares one memory refill port between
//            the icache (refill only) and the dcache (refill/writeback).
//            The grant is held until memory acknowledges. The response is
//            then returned to the granted side as a one-cycle ack.
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  wire logic             clk_i,
  input  wire logic             rst_i,
  cache_mem_arbiter_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IC_BUSY = 2'd1,
    DC_BUSY = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic c_GNT_IC = 1'b0;
  localparam logic c_GNT_DC = 1'b1;

  // Registered state and outputs
  state_t            r_state;
  logic              r_last_gnt;
  logic              r_kill;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_wdata;
  logic              r_ic_ack;
  logic              r_dc_ack;
  logic [LINE_W-1:0] r_ic_rdata;
  logic [LINE_W-1:0] r_dc_rdata;

  // Next-state values
  state_t            w_state_nxt;
  logic              w_last_gnt_nxt;
  logic              w_kill_nxt;
  logic              w_mem_req_nxt;
  logic              w_mem_we_nxt;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic [LINE_W-1:0] w_mem_wdata_nxt;
  logic              w_ic_ack_nxt;
  logic              w_dc_ack_nxt;
  logic [LINE_W-1:0] w_ic_rdata_nxt;
  logic [LINE_W-1:0] w_dc_rdata_nxt;

  logic              w_ic_elig;
  logic              w_dc_elig;
  logic              w_ic_killed;

  // A killed icache request is not eligible for a new grant
  assign w_ic_elig   = bus.ic_req_i & ~bus.ic_kill_i;
  assign w_dc_elig   = bus.dc_req_i;
  // A kill arriving together with the memory ack still suppresses the response
  assign w_ic_killed = r_kill | bus.ic_kill_i;

  // State register and all registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_last_gnt  <= c_GNT_IC;
      r_kill      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ic_ack    <= 1'b0;
      r_dc_ack    <= 1'b0;
      r_ic_rdata  <= '0;
      r_dc_rdata  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_last_gnt  <= w_last_gnt_nxt;
      r_kill      <= w_kill_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_ic_ack    <= w_ic_ack_nxt;
      r_dc_ack    <= w_dc_ack_nxt;
      r_ic_rdata  <= w_ic_rdata_nxt;
      r_dc_rdata  <= w_dc_rdata_nxt;
    end
  end

  // Grant selection, transaction tracking and response generation
  always_comb begin
    w_state_nxt     = r_state;
    w_last_gnt_nxt  = r_last_gnt;
    w_kill_nxt      = r_kill;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_ic_ack_nxt    = 1'b0;
    w_dc_ack_nxt    = 1'b0;
    w_ic_rdata_nxt  = r_ic_rdata;
    w_dc_rdata_nxt  = r_dc_rdata;

    case (r_state)
      IDLE: begin
        // On a tie the side that did not win last time gets the port
        if (w_dc_elig && (!w_ic_elig || (r_last_gnt == c_GNT_IC))) begin
          w_state_nxt     = DC_BUSY;
          w_last_gnt_nxt  = c_GNT_DC;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = bus.dc_we_i;
          w_mem_addr_nxt  = bus.dc_addr_i;
          w_mem_wdata_nxt = bus.dc_wdata_i;
        end else if (w_ic_elig) begin
          w_state_nxt     = IC_BUSY;
          w_last_gnt_nxt  = c_GNT_IC;
          w_kill_nxt      = 1'b0;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = 1'b0;
          w_mem_addr_nxt  = bus.ic_addr_i;
          w_mem_wdata_nxt = '0;
        end
      end

      IC_BUSY: begin
        if (bus.mem_ack_i) begin
          w_mem_req_nxt = 1'b0;
          if (w_ic_killed) begin
            // Memory finished but the icache no longer wants the line
            w_kill_nxt  = 1'b0;
            w_state_nxt = IDLE;
          end else begin
            w_ic_rdata_nxt = bus.mem_rdata_i;
            w_ic_ack_nxt   = 1'b1;
            w_state_nxt    = RESP;
          end
        end else if (bus.ic_kill_i) begin
          w_kill_nxt = 1'b1;
        end
      end

      DC_BUSY: begin
        if (bus.mem_ack_i) begin
          w_mem_req_nxt  = 1'b0;
          w_dc_rdata_nxt = bus.mem_rdata_i;
          w_dc_ack_nxt   = 1'b1;
          w_state_nxt    = RESP;
        end
      end

      RESP: begin
        // The ack pulse is on the outputs this cycle; it drops on exit
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.mem_req_o   = r_mem_req;
  assign bus.mem_we_o    = r_mem_we;
  assign bus.mem_addr_o  = r_mem_addr;
  assign bus.mem_wdata_o = r_mem_wdata;
  assign bus.ic_ack_o    = r_ic_ack;
  assign bus.ic_rdata_o  = r_ic_rdata;
  assign bus.dc_ack_o    = r_dc_ack;
  assign bus.dc_rdata_o  = r_dc_rdata;

endmodule
`default_nettype wire
